// File: rtl/wave_seq_ctrl.sv
// Segment-table sequencer for funct_generator: loads {sel, amp, len} per segment and
// streams len samples each. Optional WAVE_SEQ_LOOP_EN repeats the table until stopped.
module wave_seq_ctrl #(
   parameter int unsigned NUM_SEG  = 4,
   parameter int unsigned LEN_W    = 16,
   // Must match fifo_defines_pkg::INT_BITS of the attached generator
   parameter int unsigned INT_BITS = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start_i,
   input  logic                         stop_i,
   input  logic [$clog2(NUM_SEG):0]     num_seg_i,
   input  logic                         prog_we_i,
   input  logic [$clog2(NUM_SEG)-1:0]   prog_idx_i,
   input  logic [1:0]                   prog_sel_i,
   input  logic [INT_BITS-1:0]          prog_amp_i,
   input  logic [LEN_W-1:0]             prog_len_i,
   input  logic                         fifo_afull_i,
   input  logic                         gen_wr_en_i,
   output logic                         en_low_o,
   output logic                         enh_conf_o,
   output logic [INT_BITS-1:0]          amp_o,
   output logic [1:0]                   sel_o,
   output logic                         busy_o,
   output logic [$clog2(NUM_SEG)-1:0]   seg_idx_o,
   output logic                         done_o
);

   localparam int unsigned IDX_W  = $clog2(NUM_SEG);
   localparam int unsigned NSEG_W = IDX_W + 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StConf = 2'd1;
   localparam logic [1:0] StRun  = 2'd2;
   localparam logic [1:0] StNext = 2'd3;

   logic [1:0]          sel_tab [NUM_SEG];
   logic [INT_BITS-1:0] amp_tab [NUM_SEG];
   logic [LEN_W-1:0]    len_tab [NUM_SEG];

   logic [1:0]          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NSEG_W-1:0]   nseg_q, nseg_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic                act_q, act_d;
   logic                en_low_d, enh_d, busy_d, done_d;
   logic [INT_BITS-1:0] amp_d;
   logic [1:0]          sel_d;
   logic                last_seg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SEG; i++) begin
            sel_tab[i] <= '0;
            amp_tab[i] <= '0;
            len_tab[i] <= '0;
         end
      end else if (prog_we_i && (state_q == StIdle)) begin
         sel_tab[prog_idx_i] <= prog_sel_i;
         amp_tab[prog_idx_i] <= prog_amp_i;
         len_tab[prog_idx_i] <= prog_len_i;
      end
   end

   assign last_seg = (({1'b0, idx_q} + NSEG_W'(1)) == nseg_q);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      nseg_d   = nseg_q;
      cnt_d    = cnt_q;
      act_d    = act_q;
      en_low_d = 1'b1;
      enh_d    = 1'b0;
      done_d   = 1'b0;
      amp_d    = amp_o;
      sel_d    = sel_o;

      case (state_q)
         StIdle: begin
            if (start_i) begin
               nseg_d  = (num_seg_i == '0) ? NSEG_W'(1) : num_seg_i;
               idx_d   = '0;
               act_d   = 1'b0;
               state_d = StConf;
            end
         end
         StConf: begin
            if (len_tab[idx_q] == '0) begin
               state_d = StNext;
            end else begin
               cnt_d    = '0;
               en_low_d = fifo_afull_i;
               state_d  = StRun;
            end
         end
         StRun: begin
            en_low_d = fifo_afull_i;
            if (gen_wr_en_i) begin
               cnt_d = cnt_q + LEN_W'(1);
               if (cnt_d == len_tab[idx_q]) begin
                  en_low_d = 1'b1;
                  state_d  = StNext;
               end
            end
         end
         StNext: begin
            if (last_seg) begin
`ifdef WAVE_SEQ_LOOP_EN
               // A pass that loaded nothing would spin forever; finish it instead
               if (act_q) begin
                  idx_d   = '0;
                  act_d   = 1'b0;
                  state_d = StConf;
               end else begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
`else
               done_d  = 1'b1;
               state_d = StIdle;
`endif
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = StConf;
            end
         end
         default: state_d = StIdle;
      endcase

      if (stop_i) begin
         state_d  = StIdle;
         en_low_d = 1'b1;
         done_d   = 1'b0;
      end

      // Outputs are registered, so the config pulse is decided on entry to CONF
      if ((state_d == StConf) && (len_tab[idx_d] != '0)) begin
         enh_d = 1'b1;
         amp_d = amp_tab[idx_d];
         sel_d = sel_tab[idx_d];
         act_d = 1'b1;
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         nseg_q     <= NSEG_W'(1);
         cnt_q      <= '0;
         act_q      <= 1'b0;
         en_low_o   <= 1'b1;
         enh_conf_o <= 1'b0;
         amp_o      <= '0;
         sel_o      <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         nseg_q     <= nseg_d;
         cnt_q      <= cnt_d;
         act_q      <= act_d;
         en_low_o   <= en_low_d;
         enh_conf_o <= enh_d;
         amp_o      <= amp_d;
         sel_o      <= sel_d;
         busy_o     <= busy_d;
         done_o     <= done_d;
      end
   end

   assign seg_idx_o = idx_q;

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Directed bench for wave_seq_ctrl; default build checks single-pass behaviour,
// WAVE_SEQ_LOOP_EN build checks the repeating sequence.
module tb_wave_seq_ctrl;

   localparam int NUM_SEG  = 4;
   localparam int LEN_W    = 16;
   localparam int INT_BITS = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0, stop = 1'b0;
   logic [2:0]          num_seg = 3'd1;
   logic                prog_we = 1'b0;
   logic [1:0]          prog_idx = '0;
   logic [1:0]          prog_sel = '0;
   logic [INT_BITS-1:0] prog_amp = '0;
   logic [LEN_W-1:0]    prog_len = '0;
   logic                afull = 1'b0, gen = 1'b0;
   logic                en_low, enh, busy, done;
   logic [INT_BITS-1:0] amp;
   logic [1:0]          sel, seg_idx;

   int n_vec = 0;
   int n_fail = 0;

   wave_seq_ctrl #(.NUM_SEG(NUM_SEG), .LEN_W(LEN_W), .INT_BITS(INT_BITS)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .num_seg_i(num_seg),
      .prog_we_i(prog_we), .prog_idx_i(prog_idx), .prog_sel_i(prog_sel),
      .prog_amp_i(prog_amp), .prog_len_i(prog_len), .fifo_afull_i(afull),
      .gen_wr_en_i(gen), .en_low_o(en_low), .enh_conf_o(enh), .amp_o(amp), .sel_o(sel),
      .busy_o(busy), .seg_idx_o(seg_idx), .done_o(done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired: got timeout, want completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input int idx, input logic [1:0] s, input logic [15:0] a,
                       input logic [15:0] l);
      prog_we = 1'b1; prog_idx = idx[1:0]; prog_sel = s; prog_amp = a; prog_len = l;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic do_start(input int n);
      num_seg = n[2:0];
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #23 rst_n = 1'b1;
      tick();
      n_vec++; if (en_low !== 1'b1) begin n_fail++; $display("FAIL reset_en_low got %b want 1", en_low); end
      n_vec++; if (enh !== 1'b0) begin n_fail++; $display("FAIL reset_enh got %b want 0", enh); end
      n_vec++; if (amp !== 16'd0) begin n_fail++; $display("FAIL reset_amp got %0h want 0", amp); end
      n_vec++; if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", sel); end
      n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (seg_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", seg_idx); end
      n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
   endtask

   task automatic test_single();
      prog(0, 2'd2, 16'd5, 16'd8);
      do_start(1);
      n_vec++; if (enh !== 1'b1) begin n_fail++; $display("FAIL single_enh got %b want 1", enh); end
      n_vec++; if (sel !== 2'd2) begin n_fail++; $display("FAIL single_sel got %0d want 2", sel); end
      n_vec++; if (amp !== 16'd5) begin n_fail++; $display("FAIL single_amp got %0d want 5", amp); end
      n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
      n_vec++; if (en_low !== 1'b1) begin n_fail++; $display("FAIL single_conf_en got %b want 1", en_low); end
      tick();
      n_vec++; if (enh !== 1'b0) begin n_fail++; $display("FAIL single_enh_pulse got %b want 0", enh); end
      n_vec++; if (en_low !== 1'b0) begin n_fail++; $display("FAIL single_run_en got %b want 0", en_low); end
      gen = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_vec++;
         if (en_low !== (i == 7)) begin
            n_fail++; $display("FAIL single_sample%0d en_low got %b want %b", i, en_low, i == 7);
         end
      end
      // one straggler pulse while in NEXT must be ignored
      tick();
      gen = 1'b0;
      n_vec++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done got %b want 1", done); end
      n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b want 0", busy); end
      tick();
      n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse got %b want 0", done); end
   endtask

   task automatic test_three();
      int n_conf = 0, n_samp = 0, n_done = 0, first = -1, second = -1;
      prog(0, 2'd0, 16'd1, 16'd3);
      prog(1, 2'd1, 16'd2, 16'd0);
      prog(2, 2'd3, 16'hFFFD, 16'd4);
      do_start(3);
      for (int c = 0; c < 40; c++) begin
         if (enh) begin
            if (n_conf == 0) first = int'(seg_idx);
            else if (n_conf == 1) begin
               second = int'(seg_idx);
               n_vec++;
               if (sel !== 2'd3 || amp !== 16'hFFFD) begin
                  n_fail++; $display("FAIL three_seg2_cfg got sel=%0d amp=%0h want 3 fffd", sel, amp);
               end
            end
            n_conf++;
         end
         if (done) n_done++;
         gen = ~en_low;
         if (gen) n_samp++;
         tick();
      end
      gen = 1'b0;
      n_vec++; if (n_conf != 2) begin n_fail++; $display("FAIL three_conf_count got %0d want 2", n_conf); end
      n_vec++; if (first != 0) begin n_fail++; $display("FAIL three_first_idx got %0d want 0", first); end
      n_vec++; if (second != 2) begin n_fail++; $display("FAIL three_second_idx got %0d want 2", second); end
      n_vec++; if (n_samp != 7) begin n_fail++; $display("FAIL three_samples got %0d want 7", n_samp); end
      n_vec++; if (n_done != 1) begin n_fail++; $display("FAIL three_done_count got %0d want 1", n_done); end
      n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL three_idle got %b want 0", busy); end
   endtask

   task automatic test_backpressure();
      int n_samp = 0;
      logic exp_en, exp_done;
      prog(0, 2'd1, 16'd100, 16'd10);
      do_start(1);
      tick();
      n_vec++; if (en_low !== 1'b0) begin n_fail++; $display("FAIL bp_run_en got %b want 0", en_low); end
      for (int k = 0; k < 20; k++) begin
         afull = (k >= 3 && k <= 7);
         gen = ~en_low;
         if (gen) n_samp++;
         tick();
         exp_en = (k >= 3 && k <= 7) || (k >= 14);
         exp_done = (k == 15);
         n_vec++;
         if (en_low !== exp_en) begin
            n_fail++; $display("FAIL bp_en_low k=%0d got %b want %b", k, en_low, exp_en);
         end
         n_vec++;
         if (done !== exp_done) begin
            n_fail++; $display("FAIL bp_done k=%0d got %b want %b", k, done, exp_done);
         end
      end
      afull = 1'b0;
      gen = 1'b0;
      n_vec++; if (n_samp != 10) begin n_fail++; $display("FAIL bp_samples got %0d want 10", n_samp); end
   endtask

   task automatic test_stop();
      prog(0, 2'd0, 16'd9, 16'd10);
      do_start(1);
      tick();
      gen = 1'b1;
      repeat (3) tick();
      gen = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy got %b want 0", busy); end
      n_vec++; if (en_low !== 1'b1) begin n_fail++; $display("FAIL stop_en_low got %b want 1", en_low); end
      n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL stop_done got %b want 0", done); end
      tick();
      n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL stop_done_late got %b want 0", done); end
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      n_vec++; if (busy !== 1'b0 || enh !== 1'b0) begin
         n_fail++; $display("FAIL start_stop_same got busy=%b enh=%b want 0 0", busy, enh);
      end
      do_start(1);
      n_vec++; if (enh !== 1'b1) begin n_fail++; $display("FAIL restart_enh got %b want 1", enh); end
      n_vec++; if (seg_idx !== 2'd0) begin n_fail++; $display("FAIL restart_idx got %0d want 0", seg_idx); end
      tick();
      gen = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_vec++;
         if (en_low !== (i == 9)) begin
            n_fail++; $display("FAIL restart_sample%0d en_low got %b want %b", i, en_low, i == 9);
         end
      end
      gen = 1'b0;
      tick();
      n_vec++; if (done !== 1'b1) begin n_fail++; $display("FAIL restart_done got %b want 1", done); end
   endtask

   task automatic test_prog_busy();
      prog(0, 2'd0, 16'd1, 16'd2);
      do_start(1);
      prog_we = 1'b1; prog_idx = 2'd0; prog_len = 16'd5;
      tick();
      prog_we = 1'b0;
      n_vec++; if (en_low !== 1'b0) begin n_fail++; $display("FAIL pbusy_run got %b want 0", en_low); end
      gen = 1'b1;
      tick();
      n_vec++; if (en_low !== 1'b0) begin n_fail++; $display("FAIL pbusy_s1 got %b want 0", en_low); end
      tick();
      gen = 1'b0;
      n_vec++; if (en_low !== 1'b1) begin n_fail++; $display("FAIL pbusy_s2 got %b want 1", en_low); end
      tick();
      n_vec++; if (done !== 1'b1) begin n_fail++; $display("FAIL pbusy_done got %b want 1", done); end
   endtask

   task automatic test_loop();
      int n_conf = 0, n_done = 0;
      prog(0, 2'd0, 16'd3, 16'd2);
      prog(1, 2'd2, 16'd4, 16'd2);
      do_start(2);
      for (int c = 0; c < 40; c++) begin
         if (enh) begin
            n_vec++;
            if (seg_idx !== n_conf[1:0] % 2'd2) begin
               n_fail++; $display("FAIL loop_idx pulse%0d got %0d want %0d", n_conf, seg_idx, n_conf % 2);
            end
            n_conf++;
         end
         if (done) n_done++;
         prog_we = (c == 5); prog_idx = 2'd1; prog_len = 16'd0;
         gen = ~en_low;
         tick();
      end
      prog_we = 1'b0;
      gen = 1'b0;
      n_vec++; if (n_conf != 10) begin n_fail++; $display("FAIL loop_conf_count got %0d want 10", n_conf); end
      n_vec++; if (n_done != 0) begin n_fail++; $display("FAIL loop_done_count got %0d want 0", n_done); end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_vec++; if (busy !== 1'b0 || done !== 1'b0 || en_low !== 1'b1) begin
         n_fail++; $display("FAIL loop_stop got busy=%b done=%b en_low=%b want 0 0 1", busy, done, en_low);
      end
   endtask

   task automatic test_reset_mid();
      prog(0, 2'd1, 16'd7, 16'd10);
      do_start(1);
      tick();
      gen = 1'b1;
      repeat (2) tick();
      #2 rst_n = 1'b0;
      #1;
      gen = 1'b0;
      n_vec++; if (en_low !== 1'b1 || enh !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_ctl got en_low=%b enh=%b busy=%b done=%b want 1 0 0 0",
                            en_low, enh, busy, done);
      end
      n_vec++; if (amp !== 16'd0 || sel !== 2'd0 || seg_idx !== 2'd0) begin
         n_fail++; $display("FAIL rst_mid_data got amp=%0h sel=%0d idx=%0d want 0 0 0", amp, sel, seg_idx);
      end
      #3 rst_n = 1'b1;
      tick();
      // cleared table plus num_seg=0 (clamped to 1): CONF, NEXT, then IDLE with done
      do_start(0);
      n_vec++; if (enh !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL rst_tab_conf got enh=%b busy=%b want 0 1", enh, busy);
      end
      tick();
      tick();
      n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_tab_done got done=%b busy=%b want 1 0", done, busy);
      end
      n_vec++; if (amp !== 16'd0) begin n_fail++; $display("FAIL rst_tab_amp got %0h want 0", amp); end
   endtask

   initial begin
      test_reset();
`ifdef WAVE_SEQ_LOOP_EN
      test_loop();
`else
      test_single();
      test_three();
      test_backpressure();
      test_stop();
      test_prog_busy();
`endif
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/wave_seq_ctrl.md
# wave_seq_ctrl

Sequencer that drives the configuration and enable inputs of `funct_generator` from a small programmable table of waveform segments. Each segment is a waveform select, an amplitude and a sample count. The block loads each segment into the generator, lets it stream exactly that many samples into the FIFO, and throttles on FIFO almost-full. It sits between the system control registers and the generator, and observes the generator's FIFO write strobe to count samples.

## Interface
Parameters:
- `NUM_SEG`, 4: number of segment table entries; power of two.
- `LEN_W`, 16: width of the per-segment sample count.
- `INT_BITS`: amplitude width, from `fifo_defines_pkg`.

Ports:
- `clk`  in  1  clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  pulse; begins a sequence from segment 0 when idle.
- `stop_i`  in  1  pulse; aborts the sequence.
- `num_seg_i`  in  $clog2(NUM_SEG)+1  number of active segments, 1..NUM_SEG; sampled at start.
- `prog_we_i`  in  1  table write strobe.
- `prog_idx_i`  in  $clog2(NUM_SEG)  table entry to write.
- `prog_sel_i`  in  2  waveform select for the entry.
- `prog_amp_i`  in  INT_BITS  signed amplitude for the entry.
- `prog_len_i`  in  LEN_W  sample count for the entry.
- `fifo_afull_i`  in  1  FIFO almost-full.
- `gen_wr_en_i`  in  1  generator `wr_en_o`; one pulse per sample.
- `en_low_o`  out  1  active-low generator enable.
- `enh_conf_o`  out  1  one-cycle configuration pulse to the generator.
- `amp_o`  out  INT_BITS  amplitude to the generator.
- `sel_o`  out  2  waveform select to the generator.
- `busy_o`  out  1  high while not idle.
- `seg_idx_o`  out  $clog2(NUM_SEG)  current segment.
- `done_o`  out  1  one-cycle pulse when a sequence completes.

## Operation
- Table: NUM_SEG entries of {sel, amp, len}. A write takes effect at the clock edge. `prog_we_i` is ignored unless the state is IDLE. The table is cleared to zero on reset.
- FSM states:
  - IDLE: `start_i` latches `num_seg_i` (0 is clamped to 1), sets idx=0 and goes to CONF.
  - CONF: if `len[idx]` is 0, go to NEXT. Otherwise drive `amp_o`/`sel_o` from the entry, pulse `enh_conf_o` for one cycle, clear the sample counter and go to RUN.
  - RUN: `en_low_o`=0 while `fifo_afull_i`=0, and 1 while `fifo_afull_i`=1. Each `gen_wr_en_i` increments the counter. When the counter reaches `len[idx]` (the pulse that makes count==len), go to NEXT.
  - NEXT: if idx==num_seg-1, wrap per Configuration; otherwise increment idx and go to CONF.
- `gen_wr_en_i` pulses outside RUN are ignored.
- `amp_o`/`sel_o` hold the last loaded values outside CONF.
- `stop_i` in any non-IDLE state sends the FSM to IDLE on the next edge, with `en_low_o`=1 and no `done_o`.
- `start_i` and `stop_i` in the same cycle: stop wins, and the FSM stays or returns to IDLE.
- A full pass over all segments with every active len=0 always terminates to IDLE with `done_o`, in either configuration.

## Timing
- Reset values: `en_low_o`=1, `enh_conf_o`=0, `amp_o`=0, `sel_o`=0, `busy_o`=0, `seg_idx_o`=0, `done_o`=0, state IDLE.
- All outputs are registered.
- Latency for a segment with nonzero len:
  - `start_i` at edge N puts CONF at N+1.
  - `enh_conf_o` is high in cycle N+1→N+2.
  - RUN starts at N+2, and `en_low_o` falls at N+2 if not almost-full.
- `en_low_o` follows `fifo_afull_i` with one cycle of latency. The almost-full threshold must leave at least 2 entries of margin.
- The last counted sample causes `en_low_o`=1 at the next edge. Any one straggler sample from the generator is not counted.
- Segment-to-segment gap is 2 cycles (NEXT, CONF) with `en_low_o`=1.
- `done_o` pulses in the cycle the FSM enters IDLE after the final NEXT.
- `busy_o` is high from the edge after `start_i` until IDLE is re-entered.

## Configuration
- `WAVE_SEQ_LOOP_EN` defined: NEXT on the last segment sets idx=0 and goes to CONF. The sequence repeats until `stop_i`, and `done_o` never pulses except in the all-zero-length case.
- Not defined: NEXT on the last segment goes to IDLE and pulses `done_o`. The sequence is single-pass.

## Test plan
- Single segment: program idx0={sel=2, amp=5, len=8}, num_seg=1, start, FIFO never full.
  - Expect one `enh_conf_o` pulse with `sel_o`=2 and `amp_o`=5.
  - Expect `en_low_o` low until the 8th `gen_wr_en_i`, then `done_o` (non-loop build).
- Three segments with lens 3, 0, 4: expect CONF for idx0 and idx2 only, 7 counted samples and one `done_o`. The segment with len 0 gets no `enh_conf_o`.
- Backpressure: assert `fifo_afull_i` for 5 cycles mid-RUN.
  - Expect `en_low_o`=1 for exactly those 5 cycles, delayed by one cycle.
  - Expect the counter to hold and the total sample count to still equal len.
- Stop mid-RUN after 3 of 10 samples: expect IDLE next cycle, `en_low_o`=1, no `done_o`. Then start again and expect a restart at segment 0 with the count cleared.
- Reset mid-RUN (`rst_n` low asynchronously): all outputs go to reset values immediately and the table is cleared.
- `WAVE_SEQ_LOOP_EN` build, 2 segments with len 2 each: expect an idx sequence of 0,1,0,1,… with no `done_o` until stop. `prog_we_i` while busy must not change the table.
